// File: rtl/priority_arbiter4.sv
// Four-requester arbiter with fixed-priority or round-robin selection, a one-cycle bubble
// after every release, and a hold limit that forces the owner off when others are waiting.
module priority_arbiter4 #(
    parameter int HOLD_MAX = 8,
    parameter int RR_EN    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       valid,
    output logic       timeout
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state, state_nxt;
    logic [3:0] gnt_nxt, mask, mask_nxt, eligible;
    logic [1:0] gnt_id_nxt, last, last_nxt, start, winner;
    logic       valid_nxt, timeout_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;

    // Downward circular search from 'from'; fixed priority is the special case from=3.
    function automatic logic [1:0] pick(input logic [3:0] elig, input logic [1:0] from);
        logic [1:0] idx;
        logic       found;
        pick  = from;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = from - 2'(k);
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign eligible = req & ~mask;
    assign start    = (RR_EN != 0) ? last - 2'd1 : 2'd3;
    assign winner   = pick(eligible, start);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt    = state;
        gnt_nxt      = gnt;
        gnt_id_nxt   = gnt_id;
        valid_nxt    = valid;
        timeout_nxt  = 1'b0;
        hold_cnt_nxt = hold_cnt;
        last_nxt     = last;
        mask_nxt     = mask;

        unique case (state)
            IDLE: begin
                // The mask only ever covers the single arbitration right after a forced release.
                mask_nxt = 4'b0000;
                if (|eligible) begin
                    state_nxt    = GRANT;
                    gnt_nxt      = 4'(4'b0001 << winner);
                    gnt_id_nxt   = winner;
                    valid_nxt    = 1'b1;
                    hold_cnt_nxt = 8'd0;
                    last_nxt     = winner;
                end else begin
                    gnt_nxt    = 4'b0000;
                    gnt_id_nxt = 2'd0;
                    valid_nxt  = 1'b0;
                end
            end
            GRANT: begin
                if (!req[gnt_id]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    valid_nxt = 1'b0;
                end else if (hold_cnt == HOLD_LAST && |(req & ~gnt)) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = 4'b0000;
                    valid_nxt   = 1'b0;
                    mask_nxt    = gnt;
                    timeout_nxt = 1'b1;
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            gnt_id   <= 2'd0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= 8'd0;
            last     <= 2'd0;
            mask     <= 4'b0000;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            gnt_id   <= gnt_id_nxt;
            valid    <= valid_nxt;
            timeout  <= timeout_nxt;
            hold_cnt <= hold_cnt_nxt;
            last     <= last_nxt;
            mask     <= mask_nxt;
        end
    end

endmodule

// File: tb/tb_priority_arbiter4.sv
// Directed bench for priority_arbiter4: four instances (fixed, timeout, round-robin, short hold)
// share clock and reset; each step queues its expected outputs and compares them after the edge.
module tb_priority_arbiter4;

    typedef struct {
        string      tag;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       valid;
        logic       timeout;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req0, req1, req2, req3;
    logic [3:0] gnt0, gnt1, gnt2, gnt3;
    logic [1:0] id0, id1, id2, id3;
    logic       v0, v1, v2, v3;
    logic       to0, to1, to2, to3;

    int   sel;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    priority_arbiter4 #(.HOLD_MAX(8), .RR_EN(0)) dut_fp (
        .clk(clk), .reset(reset), .req(req0), .gnt(gnt0), .gnt_id(id0), .valid(v0), .timeout(to0));
    priority_arbiter4 #(.HOLD_MAX(4), .RR_EN(0)) dut_to (
        .clk(clk), .reset(reset), .req(req1), .gnt(gnt1), .gnt_id(id1), .valid(v1), .timeout(to1));
    priority_arbiter4 #(.HOLD_MAX(8), .RR_EN(1)) dut_rr (
        .clk(clk), .reset(reset), .req(req2), .gnt(gnt2), .gnt_id(id2), .valid(v2), .timeout(to2));
    priority_arbiter4 #(.HOLD_MAX(2), .RR_EN(0)) dut_mk (
        .clk(clk), .reset(reset), .req(req3), .gnt(gnt3), .gnt_id(id3), .valid(v3), .timeout(to3));

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive req on the selected instance, queue the expectation, then compare after the edge.
    task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] eid,
                        input logic ev, input logic eto, input string tag);
        exp_t       e, x;
        logic [3:0] og;
        logic [1:0] oid;
        logic       ov, oto;
        case (sel)
            0:       req0 = r;
            1:       req1 = r;
            2:       req2 = r;
            default: req3 = r;
        endcase
        e.tag = tag; e.gnt = eg; e.id = eid; e.valid = ev; e.timeout = eto;
        sb.push_back(e);
        @(posedge clk);
        #1;
        case (sel)
            0:       begin og = gnt0; oid = id0; ov = v0; oto = to0; end
            1:       begin og = gnt1; oid = id1; ov = v1; oto = to1; end
            2:       begin og = gnt2; oid = id2; ov = v2; oto = to2; end
            default: begin og = gnt3; oid = id3; ov = v3; oto = to3; end
        endcase
        x = sb.pop_front();
        check({x.tag, ".gnt"}, og, x.gnt);
        check({x.tag, ".id"}, {2'b00, oid}, {2'b00, x.id});
        check({x.tag, ".valid"}, {3'b000, ov}, {3'b000, x.valid});
        check({x.tag, ".timeout"}, {3'b000, oto}, {3'b000, x.timeout});
        check({x.tag, ".onehot"}, {3'b000, $onehot0(og) && (ov === (og != 4'b0000))}, 4'b0001);
    endtask

    initial begin
        reset = 1'b1;
        req0 = 4'b0000; req1 = 4'b0000; req2 = 4'b0000; req3 = 4'b0000;
        sel = 0;
        @(negedge clk);

        // Reset state, with a request present that must be ignored while reset is high.
        step(4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_a");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_b");
        reset = 1'b0;

        // Fixed priority.
        step(4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0, "fp_g3");
        step(4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0, "fp_hold3");
        step(4'b0011, 4'b0000, 2'd3, 1'b0, 1'b0, "fp_rel3");
        step(4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0, "fp_g1");
        step(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "fp_rel1");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "fp_idle");

        // Release and one-cycle bubble.
        step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "bub_g2a");
        step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "bub_g2b");
        step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "bub_g2c");
        step(4'b0001, 4'b0000, 2'd2, 1'b0, 1'b0, "bub_idle");
        step(4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "bub_g0");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "bub_rel0");

        // Timeout with HOLD_MAX=4.
        sel = 1;
        step(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "to_h0");
        step(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "to_h1");
        step(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "to_h2");
        step(4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "to_h3");
        step(4'b1001, 4'b0000, 2'd3, 1'b0, 1'b1, "to_forced");
        step(4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, "to_g0_masked3");
        step(4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, "to_rel0");
        step(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "to_g3_unmasked");
        // Alone past the limit: grant continues until someone else asks.
        for (int i = 0; i < 6; i++)
            step(4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "to_alone");
        step(4'b1100, 4'b0000, 2'd3, 1'b0, 1'b1, "to_sat_forced");
        step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "to_g2");
        step(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "to_rel2");

        // Round-robin.
        sel = 2;
        step(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0, "rr_g3");
        step(4'b0111, 4'b0000, 2'd3, 1'b0, 1'b0, "rr_rel3");
        step(4'b1111, 4'b0100, 2'd2, 1'b1, 1'b0, "rr_g2");
        step(4'b1011, 4'b0000, 2'd2, 1'b0, 1'b0, "rr_rel2");
        step(4'b1111, 4'b0010, 2'd1, 1'b1, 1'b0, "rr_g1");
        step(4'b1101, 4'b0000, 2'd1, 1'b0, 1'b0, "rr_rel1");
        step(4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_g0");
        step(4'b1110, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_rel0");
        step(4'b1111, 4'b1000, 2'd3, 1'b1, 1'b0, "rr_g3_wrap");
        step(4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0, "rr_rel3b");

        // Lone masked owner with HOLD_MAX=2.
        sel = 3;
        step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "mk_g2");
        step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "mk_h1");
        step(4'b0110, 4'b0000, 2'd2, 1'b0, 1'b1, "mk_forced");
        step(4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0, "mk_g1");
        step(4'b0100, 4'b0000, 2'd1, 1'b0, 1'b0, "mk_rel1");
        step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "mk_g2b");
        step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "mk_h1b");
        step(4'b0110, 4'b0000, 2'd2, 1'b0, 1'b1, "mk_forced_b");
        step(4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, "mk_lone_masked");
        step(4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "mk_regrant2");
        step(4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "mk_rel2");

        // Reset in the middle of a grant.
        sel = 0;
        step(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "rst_g1");
        step(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "rst_hold1");
        reset = 1'b1;
        step(4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_mid");
        reset = 1'b0;
        step(4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "rst_regrant");
        step(4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "rst_rel");

        check("sb_empty", 4'(sb.size()), 4'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
